// File: rtl/set_bit_dispatcher_pkg.sv
// set_bit_dispatcher_pkg: shared constants, FSM states and scan-order selection
// Build option: define SET_BIT_DISPATCHER_LSB_FIRST_EN to emit the lowest set bit first.
package set_bit_dispatcher_pkg;
  localparam int DISP_WIDTH = 32;
  localparam int DISP_IDX_W = 5;
  typedef enum logic [0:0] {DISP_IDLE = 1'b0, DISP_SCAN = 1'b1} disp_state_e;
`ifdef SET_BIT_DISPATCHER_LSB_FIRST_EN
  localparam bit DISP_LSB_FIRST = 1'b1;
`else
  localparam bit DISP_LSB_FIRST = 1'b0;
`endif
endpackage

// File: rtl/set_bit_dispatcher_enc.sv
// priority_enc32: combinational first-set-bit finder
// Ports: mask in, idx = position of the first set bit in scan order, onehot = that bit alone.
module priority_enc32
  import set_bit_dispatcher_pkg::*;
#(
  parameter int WIDTH = DISP_WIDTH,
  parameter int IDX_W = DISP_IDX_W
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);
  // Later iterations win, so walking the scan order backwards leaves the first bit in idx.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (mask[DISP_LSB_FIRST ? WIDTH-1-i : i]) idx = IDX_W'(DISP_LSB_FIRST ? WIDTH-1-i : i);
    onehot = (|mask) ? (WIDTH'(1) << idx) : '0;
  end
endmodule

// File: rtl/set_bit_dispatcher.sv
// set_bit_dispatcher: emits the index of every set bit of a word, one per out handshake
// Ports: clock/reset (sync, active-high); in_valid/in_ready/in_word accept a mask in IDLE;
// out_valid/out_ready/out_index/out_last stream indices in SCAN; done pulses after each word; busy = SCAN.
// Scan order is MSB-first unless SET_BIT_DISPATCHER_LSB_FIRST_EN is defined.
module set_bit_dispatcher
  import set_bit_dispatcher_pkg::*;
#(
  parameter int WIDTH = DISP_WIDTH,
  parameter int IDX_W = DISP_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic             busy
);
  disp_state_e state;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] hot;
  logic [IDX_W-1:0] idx;
  priority_enc32 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (.mask(mask), .idx(idx), .onehot(hot));
  always_comb begin
    busy      = state == DISP_SCAN;
    in_ready  = !busy;
    out_valid = busy;
    out_index = busy ? idx : '0;
    // Last when nothing remains once the current bit is removed.
    out_last  = busy && ((mask & ~hot) == '0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DISP_IDLE;
      mask  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_valid && in_ready) begin
        mask <= in_word;
        if (in_word == '0) done <= 1'b1;
        else state <= DISP_SCAN;
      end else if (out_valid && out_ready) begin
        mask <= mask & ~hot;
        if (out_last) begin
          state <= DISP_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_set_bit_dispatcher.sv
// tb_set_bit_dispatcher: directed self-checking bench for set_bit_dispatcher
module tb_set_bit_dispatcher;
`ifdef SET_BIT_DISPATCHER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_index;
  logic        out_last;
  logic        done;
  logic        busy;
  int n_checks = 0;
  int n_fail = 0;
  set_bit_dispatcher dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_last(out_last),
    .done(done), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic idx_is(input string tag, input int exp, input logic last);
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " idx"}, out_index, exp);
    check({tag, " last"}, out_last, last);
  endtask
  initial begin
    @(negedge clock);
    step();
    check("rst out_valid", out_valid, 0);
    check("rst out_index", out_index, 0);
    check("rst out_last", out_last, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    reset = 1'b0;
    // 0x8000_0001: two indices then done
    in_valid = 1'b1; in_word = 32'h8000_0001;
    check("t1 in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t1 busy", busy, 1);
    check("t1 in_ready scan", in_ready, 0);
    idx_is("t1 first", LSB ? 0 : 31, 0);
    step();
    idx_is("t1 second", LSB ? 31 : 0, 1);
    step();
    check("t1 done", done, 1);
    check("t1 in_ready", in_ready, 1);
    check("t1 out_valid", out_valid, 0);
    step();
    check("t1 done drop", done, 0);
    // zero word
    in_valid = 1'b1; in_word = 32'h0;
    step();
    in_valid = 1'b0;
    check("t2 done", done, 1);
    check("t2 out_valid", out_valid, 0);
    check("t2 in_ready", in_ready, 1);
    step();
    check("t2 done drop", done, 0);
    check("t2 out_valid", out_valid, 0);
    // all ones: 32 consecutive indices, done on cycle 33
    in_valid = 1'b1; in_word = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      idx_is($sformatf("t3 k%0d", k), LSB ? k : 31 - k, k == 31);
      check("t3 no done", done, 0);
      step();
    end
    check("t3 done", done, 1);
    check("t3 out_valid", out_valid, 0);
    step();
    // 0xA0 with backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_word = 32'h0000_00A0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx_is($sformatf("t4 hold%0d", k), LSB ? 5 : 7, 0);
      step();
    end
    out_ready = 1'b1;
    idx_is("t4 rel first", LSB ? 5 : 7, 0);
    step();
    idx_is("t4 rel second", LSB ? 7 : 5, 1);
    step();
    check("t4 done", done, 1);
    step();
    // reset during the third index of 0xF
    in_valid = 1'b1; in_word = 32'h0000_000F;
    step();
    in_valid = 1'b0;
    idx_is("t5 i0", LSB ? 0 : 3, 0);
    step();
    idx_is("t5 i1", LSB ? 1 : 2, 0);
    step();
    idx_is("t5 i2", LSB ? 2 : 1, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5 out_valid", out_valid, 0);
    check("t5 busy", busy, 0);
    check("t5 in_ready", in_ready, 1);
    check("t5 done", done, 0);
    step();
    check("t5 done later", done, 0);
    check("t5 out_valid later", out_valid, 0);
    in_valid = 1'b1; in_word = 32'h0000_0002;
    step();
    in_valid = 1'b0;
    idx_is("t5 fresh", 1, 1);
    step();
    check("t5 fresh done", done, 1);
    step();
    // back-to-back words with in_valid held
    in_valid = 1'b1; in_word = 32'h0000_0001;
    step();
    in_word = 32'h0000_0004;
    idx_is("t6 w1", 0, 1);
    check("t6 in_ready scan", in_ready, 0);
    step();
    check("t6 done", done, 1);
    check("t6 in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    idx_is("t6 w2", 2, 1);
    step();
    check("t6 done2", done, 1);
    check("t6 out_valid", out_valid, 0);
    step();
    check("t6 idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
